// File: rtl/inst_fetch_buf_pkg.sv
// Shared widths, line geometry and FSM encoding for the one-line instruction fetch buffer.
package inst_fetch_buf_pkg;

    localparam int InstAddressBus = 32;
    localparam int InstDataBus    = 32;
    localparam int IFB_LINE_WORDS = 4;
    localparam int IfbTagBits     = InstAddressBus - 4;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } ifb_state_e;

    // Word-aligned byte address of word idx within the line named by tag.
    function automatic logic [InstAddressBus-1:0] ifb_word_addr(
        input logic [IfbTagBits-1:0] tag,
        input logic [1:0]            idx
    );
        return {tag, idx, 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_buf_if.sv
// Core-side fetch port and memory-side read port of the fetch buffer.
interface inst_fetch_buf_if;
    import inst_fetch_buf_pkg::*;

    logic                      rom_ce_i;
    logic [InstAddressBus-1:0] rom_addr_i;
    logic [InstDataBus-1:0]    rom_data_o;
    logic                      stallreq_o;
    logic                      flush_i;
    logic                      bus_req_o;
    logic [InstAddressBus-1:0] bus_addr_o;
    logic [InstDataBus-1:0]    bus_data_i;
    logic                      bus_ack_i;

    modport slave (
        input  rom_ce_i, rom_addr_i, flush_i, bus_data_i, bus_ack_i,
        output rom_data_o, stallreq_o, bus_req_o, bus_addr_o
    );

    modport master (
        output rom_ce_i, rom_addr_i, flush_i, bus_data_i, bus_ack_i,
        input  rom_data_o, stallreq_o, bus_req_o, bus_addr_o
    );

endinterface

// File: rtl/inst_fetch_buf_perf_cnt.sv
// ifb_perf_cnt: saturating hit/miss event counters, present only with IFB_PERF_CNT_EN.
// Counts on the rising edge after the event cycle; never backpressures.
`ifdef IFB_PERF_CNT_EN
module ifb_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        hit_i,
    input  logic        miss_i,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
);

    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit_i && (hit_cnt_q != 32'hFFFF_FFFF))
            hit_cnt_d = hit_cnt_q + 32'd1;
        if (miss_i && (miss_cnt_q != 32'hFFFF_FFFF))
            miss_cnt_d = miss_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

endmodule
`endif

// File: rtl/inst_fetch_buf.sv
// One-line (4-word) instruction fetch buffer; hits return data combinationally, misses refill word by word.
// Latency: hit 0 cycles; miss 5 stall cycles plus one per bus wait cycle; bus address held until bus_ack_i.
// Optional IFB_PERF_CNT_EN adds hit_cnt_o/miss_cnt_o saturating counters.
module inst_fetch_buf
    import inst_fetch_buf_pkg::*;
#(
    parameter int LINE_WORDS = IFB_LINE_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    inst_fetch_buf_if.slave   ifc
`ifdef IFB_PERF_CNT_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    ifb_state_e             state_q, state_d;
    logic                   valid_q, valid_d;
    logic [IfbTagBits-1:0]  tag_q, tag_d;
    logic [1:0]             cnt_q, cnt_d;
    logic                   flush_pend_q, flush_pend_d;
    logic [InstDataBus-1:0] line_q [LINE_WORDS];

    logic hit;
    logic miss;
    logic line_we;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^ifc.rom_addr_i[1:0];

    always_comb begin
        state_d        = state_q;
        valid_d        = valid_q;
        tag_d          = tag_q;
        cnt_d          = cnt_q;
        flush_pend_d   = flush_pend_q;
        hit            = 1'b0;
        miss           = 1'b0;
        line_we        = 1'b0;
        ifc.rom_data_o = '0;
        ifc.stallreq_o = 1'b0;
        ifc.bus_req_o  = 1'b0;
        ifc.bus_addr_o = '0;

        case (state_q)
            IDLE: begin
                flush_pend_d = 1'b0;
                hit  = ifc.rom_ce_i && valid_q &&
                       (tag_q == ifc.rom_addr_i[InstAddressBus-1:4]);
                miss = ifc.rom_ce_i && !hit;
                if (hit)
                    ifc.rom_data_o = line_q[ifc.rom_addr_i[3:2]];
                ifc.stallreq_o = miss;
                if (ifc.flush_i)
                    valid_d = 1'b0;
                if (miss) begin
                    tag_d   = ifc.rom_addr_i[InstAddressBus-1:4];
                    valid_d = 1'b0;
                    cnt_d   = 2'd0;
                    state_d = FILL;
                end
            end
            FILL: begin
                ifc.bus_req_o  = 1'b1;
                ifc.bus_addr_o = ifb_word_addr(tag_q, cnt_q);
                ifc.stallreq_o = 1'b1;
                if (ifc.flush_i)
                    flush_pend_d = 1'b1;
                if (ifc.bus_ack_i) begin
                    line_we = 1'b1;
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'(LINE_WORDS - 1)) begin
                        // A flush arriving on the final ack must also keep the line invalid.
                        valid_d      = !(flush_pend_q || ifc.flush_i);
                        flush_pend_d = 1'b0;
                        state_d      = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs go quiet the moment reset asserts, not at the next edge.
        if (!rst) begin
            hit            = 1'b0;
            miss           = 1'b0;
            ifc.rom_data_o = '0;
            ifc.stallreq_o = 1'b0;
            ifc.bus_req_o  = 1'b0;
            ifc.bus_addr_o = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            valid_q      <= 1'b0;
            tag_q        <= '0;
            cnt_q        <= 2'd0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Line data carries no reset; valid_q alone guards it.
    always_ff @(posedge clk) begin
        if (line_we)
            line_q[cnt_q] <= ifc.bus_data_i;
    end

`ifdef IFB_PERF_CNT_EN
    ifb_perf_cnt u_perf_cnt (
        .clk        (clk),
        .rst        (rst),
        .hit_i      (hit),
        .miss_i     (miss),
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
    );
`endif

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Self-checking bench for inst_fetch_buf: cycle vectors, wait-state/flush/reset sequences, randomized fetches.
module tb_inst_fetch_buf;
    import inst_fetch_buf_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_buf_if ifc ();

`ifdef IFB_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    inst_fetch_buf #(.LINE_WORDS(4)) dut (
        .clk (clk),
        .rst (rst),
        .ifc (ifc)
`ifdef IFB_PERF_CNT_EN
        ,
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h100 + {2'b00, a[31:2]};
    endfunction

    // Memory: data follows the requested address, ack pattern chosen by ack_mode.
    int ack_mode = 0;
    int wcnt     = 0;
    assign ifc.bus_data_i = mem_word(ifc.bus_addr_o);
    initial ifc.bus_ack_i = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!ifc.bus_req_o) begin
            ifc.bus_ack_i = 1'b0;
            wcnt = 0;
        end else if (ack_mode == 0) begin
            ifc.bus_ack_i = 1'b1;
        end else if (ack_mode == 1) begin
            if (wcnt == 2) begin
                ifc.bus_ack_i = 1'b1;
                wcnt = 0;
            end else begin
                ifc.bus_ack_i = 1'b0;
                wcnt++;
            end
        end else begin
            ifc.bus_ack_i = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents addr until the core is released; verifies fill addresses, ack count, stall length, data.
    task automatic fetch(input logic [31:0] a, input bit exp_hit, output int stalls);
        int  fills;
        int  acks;
        bit  done;
        logic [31:0] exp_addr;
        stalls = 0; fills = 0; acks = 0; done = 0;
        ifc.rom_ce_i   = 1'b1;
        ifc.rom_addr_i = a;
        ifc.flush_i    = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (!ifc.stallreq_o) begin
                check("fetch_data", ifc.rom_data_o, mem_word(a));
                done = 1;
            end else begin
                stalls++;
                if (ifc.bus_req_o) begin
                    fills++;
                    exp_addr = {a[31:4], 4'b0000} + 32'(acks * 4);
                    check("fill_addr", ifc.bus_addr_o, exp_addr);
                    if (ifc.bus_ack_i) acks++;
                end
            end
            if (!done) tick();
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL fetch_timeout addr=%h stalls=%0d required_release_within=300", a, stalls);
        end else begin
            check("stall_cycles", 32'(stalls), exp_hit ? 32'd0 : 32'(1 + fills));
            check("fill_acks", 32'(acks), exp_hit ? 32'd0 : 32'd4);
        end
    endtask

    typedef struct {
        bit          ce;
        logic [31:0] addr;
        bit          flush;
        bit          stall;
        bit          req;
        logic [31:0] baddr;
        logic [31:0] data;
    } vec_t;

    function automatic vec_t mk(bit ce, logic [31:0] addr, bit flush, bit stall, bit req,
                                logic [31:0] baddr, logic [31:0] data);
        vec_t v;
        v.ce = ce; v.addr = addr; v.flush = flush; v.stall = stall;
        v.req = req; v.baddr = baddr; v.data = data;
        return v;
    endfunction

    vec_t tbl [17];

    initial begin
        int          st;
        bit          valid_m;
        logic [27:0] tag_m;
        logic [31:0] a;
        bit          hit_m;

        // Cold miss, hit sweep, flush in IDLE, address change ignored during fill.
        tbl[0]  = mk(1, 32'h8,   0, 1, 0, 32'h0, 32'h0);
        tbl[1]  = mk(1, 32'h8,   0, 1, 1, 32'h0, 32'h0);
        tbl[2]  = mk(1, 32'h8,   0, 1, 1, 32'h4, 32'h0);
        tbl[3]  = mk(1, 32'h8,   0, 1, 1, 32'h8, 32'h0);
        tbl[4]  = mk(1, 32'h8,   0, 1, 1, 32'hC, 32'h0);
        tbl[5]  = mk(1, 32'h8,   0, 0, 0, 32'h0, 32'h102);
        tbl[6]  = mk(1, 32'h0,   0, 0, 0, 32'h0, 32'h100);
        tbl[7]  = mk(1, 32'h4,   0, 0, 0, 32'h0, 32'h101);
        tbl[8]  = mk(1, 32'hC,   0, 0, 0, 32'h0, 32'h103);
        tbl[9]  = mk(0, 32'h8,   0, 0, 0, 32'h0, 32'h0);
        tbl[10] = mk(0, 32'h8,   1, 0, 0, 32'h0, 32'h0);
        tbl[11] = mk(1, 32'h8,   0, 1, 0, 32'h0, 32'h0);
        tbl[12] = mk(1, 32'h3F0, 0, 1, 1, 32'h0, 32'h0);
        tbl[13] = mk(1, 32'h3F0, 0, 1, 1, 32'h4, 32'h0);
        tbl[14] = mk(0, 32'h3F4, 0, 1, 1, 32'h8, 32'h0);
        tbl[15] = mk(1, 32'h3F8, 0, 1, 1, 32'hC, 32'h0);
        tbl[16] = mk(1, 32'h8,   0, 0, 0, 32'h0, 32'h102);

        ifc.rom_ce_i   = 1'b1;
        ifc.rom_addr_i = 32'h8;
        ifc.flush_i    = 1'b0;
        #3;
        check("rst_stall", {31'b0, ifc.stallreq_o}, 32'd0);
        check("rst_req",   {31'b0, ifc.bus_req_o},  32'd0);
        check("rst_baddr", ifc.bus_addr_o,          32'd0);
        check("rst_data",  ifc.rom_data_o,          32'd0);
`ifdef IFB_PERF_CNT_EN
        check("rst_hit_cnt",  hit_cnt,  32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        ack_mode = 0;
        for (int i = 0; i < 17; i++) begin
            ifc.rom_ce_i   = tbl[i].ce;
            ifc.rom_addr_i = tbl[i].addr;
            ifc.flush_i    = tbl[i].flush;
            @(negedge clk);
            check($sformatf("vec%0d_stall", i), {31'b0, ifc.stallreq_o}, {31'b0, tbl[i].stall});
            check($sformatf("vec%0d_req", i),   {31'b0, ifc.bus_req_o},  {31'b0, tbl[i].req});
            check($sformatf("vec%0d_baddr", i), ifc.bus_addr_o,          tbl[i].baddr);
            check($sformatf("vec%0d_data", i),  ifc.rom_data_o,          tbl[i].data);
`ifdef IFB_PERF_CNT_EN
            if (i == 9) begin
                check("perf_miss_cnt", miss_cnt, 32'd1);
                check("perf_hit_cnt",  hit_cnt,  32'd4);
            end
`endif
            tick();
        end
        ifc.flush_i = 1'b0;

        // Wait states: ack every third cycle.
        ack_mode = 1;
        fetch(32'h40, 1'b0, st);
        check("wait_stall_total", 32'(st), 32'd13);
        tick();
        fetch(32'h4C, 1'b1, st);
        tick();

        // Flush pulse during the second fill word: line must stay invalid and refetch.
        ack_mode = 0;
        ifc.rom_ce_i   = 1'b1;
        ifc.rom_addr_i = 32'h80;
        tick();
        tick();
        ifc.flush_i = 1'b1;
        @(negedge clk);
        check("flushfill_baddr", ifc.bus_addr_o, 32'h84);
        check("flushfill_req",   {31'b0, ifc.bus_req_o}, 32'd1);
        tick();
        ifc.flush_i = 1'b0;
        tick();
        tick();
        fetch(32'h80, 1'b0, st);
        tick();

        // Asynchronous reset after the first ack of a fill.
        ifc.rom_ce_i   = 1'b1;
        ifc.rom_addr_i = 32'h100;
        tick();
        tick();
        #1;
        rst = 1'b0;
        #1;
        check("rstmid_req",   {31'b0, ifc.bus_req_o},  32'd0);
        check("rstmid_stall", {31'b0, ifc.stallreq_o}, 32'd0);
        check("rstmid_baddr", ifc.bus_addr_o,          32'd0);
        check("rstmid_data",  ifc.rom_data_o,          32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        fetch(32'h0, 1'b0, st);
        tick();

        // Randomized fetches against a line-level model.
        ack_mode = 2;
        ifc.rom_ce_i = 1'b0;
        ifc.flush_i  = 1'b1;
        tick();
        ifc.flush_i = 1'b0;
        valid_m = 1'b0;
        tag_m   = '0;
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                ifc.rom_ce_i = 1'b0;
                ifc.flush_i  = 1'b1;
                @(negedge clk);
                check("rnd_idle_stall", {31'b0, ifc.stallreq_o}, 32'd0);
                check("rnd_idle_data",  ifc.rom_data_o,          32'd0);
                tick();
                ifc.flush_i = 1'b0;
                valid_m = 1'b0;
            end
            a = 32'h200 + 32'($urandom_range(0, 3) << 4) + 32'($urandom_range(0, 3) << 2);
            hit_m = valid_m && (tag_m == a[31:4]);
            fetch(a, hit_m, st);
            tick();
            valid_m = 1'b1;
            tag_m   = a[31:4];
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inst_fetch_buf.md
INST_FETCH_BUF -- requirements
Module: inst_fetch_buf

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, meaning 32-bit words per buffered line; only 4 is supported.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rom_ce_i  in  1  core fetch enable.
- rom_addr_i  in  32  core fetch byte address; bits [1:0] ignored.
- rom_data_o  out  32  instruction word to core.
- stallreq_o  out  1  fetch stall request to pipeline control.
- flush_i  in  1  invalidate the buffered line.
- bus_req_o  out  1  memory read request.
- bus_addr_o  out  32  word-aligned memory read address.
- bus_data_i  in  32  memory read data, valid when bus_ack_i=1.
- bus_ack_i  in  1  memory word accepted/returned.

Function
REQ-003 SHALL hold one line: valid bit, 28-bit tag (addr[31:4]), 4 data words.
REQ-004 SHALL define hit as rom_ce_i=1, valid=1, tag==rom_addr_i[31:4], state IDLE.
REQ-005 SHALL, on hit, drive rom_data_o=line[rom_addr_i[3:2]] and stallreq_o=0 in the same cycle (combinational, zero latency).
REQ-006 SHALL, when rom_ce_i=0, drive rom_data_o=0 and stallreq_o=0 and start no request.
REQ-007 SHALL, on miss in IDLE, assert stallreq_o combinationally that cycle, latch tag=rom_addr_i[31:4], clear valid, clear word counter, and enter FILL at the next edge.
REQ-008 SHALL, in FILL, drive bus_req_o=1, bus_addr_o={tag,cnt,2'b00}, stallreq_o=1, rom_data_o=0.
REQ-009 SHALL hold bus_addr_o stable until bus_ack_i=1; on each ack, write bus_data_i to line[cnt] and increment cnt.
REQ-010 SHALL, on ack with cnt=3, set valid=1 (unless flush pending), deassert bus_req_o, and return to IDLE at that edge.
REQ-011 SHALL give a zero-wait-state miss exactly 5 stall cycles; each bus wait cycle adds one.
REQ-012 SHALL ignore rom_addr_i and rom_ce_i changes during FILL; the fill always completes and the address is then re-evaluated in IDLE.
REQ-013 SHALL, on flush_i=1 in IDLE, clear valid at the next edge; a coincident miss still starts its fill.
REQ-014 SHALL, on flush_i=1 in FILL, record a pending flush so the completed line stays invalid; the pending flag clears on return to IDLE.
REQ-015 SHALL drive bus_req_o=0 and bus_addr_o=0 in IDLE.

Reset
REQ-016 SHALL, while rst=0, immediately force state IDLE, valid=0, tag=0, cnt=0, pending flush=0, bus_req_o=0, bus_addr_o=0, stallreq_o=0, rom_data_o=0, asynchronously, including mid-fill.
REQ-017 SHALL not clear line data words on reset.

Configuration
REQ-018 SHALL, with IFB_PERF_CNT_EN defined, add outputs hit_cnt_o (32) and miss_cnt_o (32), reset to 0. hit_cnt_o increments on each hit cycle. miss_cnt_o increments on each IDLE->FILL transition. Both saturate at 32'hFFFFFFFF.
REQ-019 SHALL, without IFB_PERF_CNT_EN, have neither port nor counter logic; all other behaviour is identical.

Structure
REQ-020 SHALL take InstAddressBus, InstDataBus, the IDLE/FILL state encodings and IFB_LINE_WORDS from the shared define include.
REQ-021 SHALL place counters in sub-module ifb_perf_cnt, instantiated only under IFB_PERF_CNT_EN; all other logic stays flat.

Verification
REQ-022 Cold miss: reset, rom_ce_i=1, addr 0x0000_0008, ack every cycle with data 0x100..0x103 -> bus_addr_o 0x0,0x4,0x8,0xC; stallreq_o high 5 cycles; then rom_data_o=0x102.
REQ-023 Hit sweep: after REQ-022, addr 0x0,0x4,0xC on consecutive cycles -> rom_data_o 0x100,0x101,0x103; stallreq_o=0; bus_req_o=0.
REQ-024 Wait states: miss at 0x40 with ack only every third cycle -> bus_addr_o held between acks; stallreq_o high 1+12 cycles; line valid afterward.
REQ-025 Flush mid-fill: flush_i pulse during second word of fill at 0x80 -> fill completes; next cycle at 0x80 misses again and refetches.
REQ-026 Reset mid-fill: rst low after first ack -> bus_req_o and stallreq_o drop without waiting for an edge; after release, addr 0x0 misses.
REQ-027 With IFB_PERF_CNT_EN: REQ-022 then REQ-023 -> miss_cnt_o=1, hit_cnt_o=4.
